// File: rtl/layer_sched_pkg.sv
// Shared types and constants for the video-layer scheduler.
// Optional hit-flash sequencing is enabled by defining LAYER_SCHED_FLASH_EN.
package layer_sched_pkg;

  typedef enum logic [1:0] {
    EFF_NONE  = 2'd0,
    EFF_FLASH = 2'd1,
    EFF_FADE  = 2'd2
  } effect_t;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_FLASH    = 3'd1,
    ST_FADE_OUT = 3'd2,
    ST_BLACK    = 3'd3,
    ST_FADE_IN  = 3'd4
  } state_t;

  localparam int LAYER_PLAYER  = 0;
  localparam int LAYER_ALIEN   = 1;
  localparam int LAYER_GOLD    = 2;
  localparam int LAYER_TERRAIN = 3;
  localparam int LAYER_SHOT    = 4;
  localparam int LAYER_SCORE   = 5;
  localparam int LAYER_LIFE    = 6;
  localparam int LAYER_SPARE   = 7;

  // Slot i holds layer i after reset (slot 0 = highest priority).
  localparam logic [7:0][2:0] PRIO_RESET = {
    3'(LAYER_SPARE), 3'(LAYER_LIFE),    3'(LAYER_SCORE), 3'(LAYER_SHOT),
    3'(LAYER_TERRAIN), 3'(LAYER_GOLD), 3'(LAYER_ALIEN), 3'(LAYER_PLAYER)
  };

  localparam logic [3:0] FADE_FULL  = 4'd15;
  localparam logic [3:0] FADE_BLACK = 4'd0;

endpackage

// File: rtl/layer_scheduler_prio_select.sv
// Combinational priority scan: first table slot whose layer is requesting wins.
// Absent layers never win; a duplicated layer wins at its highest-priority slot.
module layer_prio_select #(
  parameter int NUM_LAYERS = 8,
  parameter int LW         = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0][LW-1:0] i_table,
  input  logic [NUM_LAYERS-1:0]         i_req,
  output logic                          o_valid,
  output logic [LW-1:0]                 o_layer
);

  always_comb begin
    o_valid = 1'b0;
    o_layer = '0;
    // Scan from lowest priority upward so the highest-priority hit is written last.
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if (i_req[i_table[s]]) begin
        o_valid = 1'b1;
        o_layer = i_table[s];
      end
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Frame-synchronous layer arbiter and screen-effect sequencer for the objects mux.
// Define LAYER_SCHED_FLASH_EN to include the hit-flash state and its pending flag.
module layer_scheduler
  import layer_sched_pkg::*;
#(
  parameter  int NUM_LAYERS       = 8,
  parameter  int FLASH_FRAMES     = 8,
  parameter  int FADE_STEP_FRAMES = 4,
  localparam int LW               = $clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic [NUM_LAYERS-1:0] layer_dr,
  input  logic                  prio_wr,
  input  logic [LW-1:0]         prio_slot,
  input  logic [LW-1:0]         prio_layer,
  input  logic                  hit_evt,
  input  logic                  level_end,
  input  logic                  start_level,
  output logic                  sel_valid,
  output logic [LW-1:0]         sel_layer,
  output logic [1:0]            effect,
  output logic [3:0]            fade_level,
  output logic                  fade_done,
  output logic                  busy
);

  localparam int SW = $clog2(FADE_STEP_FRAMES + 1);

  function automatic logic [3:0] fade_dec(input logic [3:0] f);
    return (f == FADE_BLACK) ? FADE_BLACK : f - 4'd1;
  endfunction

  function automatic logic [3:0] fade_inc(input logic [3:0] f);
    return (f == FADE_FULL) ? FADE_FULL : f + 4'd1;
  endfunction

  logic [NUM_LAYERS-1:0][LW-1:0] r_shadow;
  logic [NUM_LAYERS-1:0][LW-1:0] r_active;
  logic                          w_sel_valid;
  logic [LW-1:0]                 w_sel_layer;
  logic                          r_sel_valid;
  logic [LW-1:0]                 r_sel_layer;

  state_t        r_state;
  effect_t       r_effect;
  logic [3:0]    r_fade;
  logic          r_fade_done;
  logic          r_busy;
  logic [SW-1:0] r_step;
  logic          r_lvl_pend;
  logic          r_start_pend;
  logic          w_lvl;
  logic          w_start;
  logic          w_step_wrap;

  // Active table only changes at a frame start, from the pre-write shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_shadow[i] <= LW'(PRIO_RESET[i % 8]);
        r_active[i] <= LW'(PRIO_RESET[i % 8]);
      end
    end else begin
      if (startOfFrame) r_active <= r_shadow;
      if (prio_wr) r_shadow[prio_slot] <= prio_layer;
    end
  end

  layer_prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .LW         (LW)
  ) u_prio_select (
    .i_table (r_active),
    .i_req   (layer_dr),
    .o_valid (w_sel_valid),
    .o_layer (w_sel_layer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_valid <= 1'b0;
      r_sel_layer <= '0;
    end else begin
      r_sel_valid <= w_sel_valid;
      r_sel_layer <= w_sel_layer;
    end
  end

`ifdef LAYER_SCHED_FLASH_EN
  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  logic           r_hit_pend;
  logic [FCW-1:0] r_flash_cnt;
  logic [FCW-1:0] w_flash_nxt;
  logic           w_hit;
  assign w_hit       = r_hit_pend | hit_evt;
  assign w_flash_nxt = r_flash_cnt + FCW'(1);
`else
  logic w_unused_flash;
  assign w_unused_flash = hit_evt ^ (FLASH_FRAMES < 0);
`endif

  // An event arriving on the frame-start cycle itself is consumed at that frame start.
  assign w_lvl       = r_lvl_pend | level_end;
  assign w_start     = r_start_pend | start_level;
  assign w_step_wrap = (r_step == SW'(FADE_STEP_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_NORMAL;
      r_effect     <= EFF_NONE;
      r_fade       <= FADE_FULL;
      r_fade_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_step       <= '0;
      r_lvl_pend   <= 1'b0;
      r_start_pend <= 1'b0;
`ifdef LAYER_SCHED_FLASH_EN
      r_hit_pend   <= 1'b0;
      r_flash_cnt  <= '0;
`endif
    end else begin
      r_fade_done <= 1'b0;
      if (!startOfFrame) begin
        r_lvl_pend   <= w_lvl;
        r_start_pend <= w_start;
`ifdef LAYER_SCHED_FLASH_EN
        r_hit_pend   <= w_hit;
`endif
      end else begin
        // Every flag is consumed or dropped here unless a state keeps it below.
        r_lvl_pend   <= 1'b0;
        r_start_pend <= 1'b0;
`ifdef LAYER_SCHED_FLASH_EN
        r_hit_pend   <= 1'b0;
`endif
        case (r_state)
          ST_NORMAL: begin
            if (w_lvl) begin
              r_state  <= ST_FADE_OUT;
              r_effect <= EFF_FADE;
              r_fade   <= FADE_FULL;
              r_step   <= '0;
              r_busy   <= 1'b1;
`ifdef LAYER_SCHED_FLASH_EN
            end else if (w_hit) begin
              r_state     <= ST_FLASH;
              r_effect    <= EFF_FLASH;
              r_flash_cnt <= '0;
              r_busy      <= 1'b1;
`endif
            end
          end
`ifdef LAYER_SCHED_FLASH_EN
          ST_FLASH: begin
            if (w_lvl) begin
              r_state  <= ST_FADE_OUT;
              r_effect <= EFF_FADE;
              r_fade   <= FADE_FULL;
              r_step   <= '0;
            end else if (r_flash_cnt == FCW'(FLASH_FRAMES - 1)) begin
              r_state  <= ST_NORMAL;
              r_effect <= EFF_NONE;
              r_busy   <= 1'b0;
            end else begin
              r_flash_cnt <= w_flash_nxt;
              r_effect    <= w_flash_nxt[0] ? EFF_NONE : EFF_FLASH;
            end
          end
`endif
          ST_FADE_OUT: begin
            r_step <= w_step_wrap ? '0 : r_step + 1'b1;
            if (w_step_wrap) begin
              r_fade <= fade_dec(r_fade);
              if (fade_dec(r_fade) == FADE_BLACK) begin
                r_state     <= ST_BLACK;
                r_fade_done <= 1'b1;
              end
            end
          end
          ST_BLACK: begin
            r_fade <= FADE_BLACK;
            if (w_start) begin
              r_state <= ST_FADE_IN;
              r_step  <= '0;
            end
          end
          ST_FADE_IN: begin
            // A level end seen while brightening is replayed once back in NORMAL.
            r_lvl_pend <= w_lvl;
            r_step     <= w_step_wrap ? '0 : r_step + 1'b1;
            if (w_step_wrap) begin
              r_fade <= fade_inc(r_fade);
              if (fade_inc(r_fade) == FADE_FULL) begin
                r_state  <= ST_NORMAL;
                r_effect <= EFF_NONE;
                r_busy   <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= ST_NORMAL;
            r_effect <= EFF_NONE;
            r_fade   <= FADE_FULL;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel_valid  = r_sel_valid;
  assign sel_layer  = r_sel_layer;
  assign effect     = r_effect;
  assign fade_level = r_fade;
  assign fade_done  = r_fade_done;
  assign busy       = r_busy;

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Frame-synchronous controller for the video objects mux. It holds a runtime-programmable layer priority table, applied only at frame boundaries. Each pixel cycle it arbitrates the per-layer draw requests and outputs a registered winning-layer index. It also sequences screen effects (hit flash, level fade-out/fade-in) that the mux applies on top of the winning layer's colour.

## Interface
Parameters:
- NUM_LAYERS, 8, number of draw-request layers; index width LW = $clog2(NUM_LAYERS)
- FLASH_FRAMES, 8, frames spent in hit-flash sequence
- FADE_STEP_FRAMES, 4, frames per fade_level step

Ports:
- clk  in  1  pixel clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame
- layer_dr  in  NUM_LAYERS  draw request, bit i = layer i
- prio_wr  in  1  write strobe for shadow priority table
- prio_slot  in  LW  slot written (0 = highest priority)
- prio_layer  in  LW  layer index stored in that slot
- hit_evt  in  1  player-hit pulse, requests flash
- level_end  in  1  pulse, requests fade-out
- start_level  in  1  pulse, requests fade-in from black
- sel_valid  out  1  a layer is drawing this pixel
- sel_layer  out  LW  winning layer index
- effect  out  2  0 NONE, 1 FLASH (white override), 2 FADE (scale by fade_level)
- fade_level  out  4  brightness, 15 = full, 0 = black
- fade_done  out  1  one-cycle pulse on reaching black
- busy  out  1  high in any state other than NORMAL

## Operation
- Priority table: two arrays of NUM_LAYERS entries of LW bits, shadow and active.
  - prio_wr writes shadow[prio_slot] = prio_layer.
  - At startOfFrame: active <= shadow, using the pre-write shadow value if prio_wr hits the same cycle. The written value applies from the following frame.
  - Reset value of both tables: slot i = layer i (0 player, 1 alien, 2 gold, 3 terrain, 4 shot, 5 score, 6 life, 7 spare).
- Arbitration: scan slots 0..NUM_LAYERS-1; the first slot whose layer has layer_dr set wins.
  - A layer absent from the table never wins. A layer duplicated in the table wins at its highest slot.
  - No request: sel_valid = 0, sel_layer = 0.
- Events: hit_evt, level_end and start_level each set a pending flag. Flags are consumed only at startOfFrame.
- FSM: NORMAL, FLASH, FADE_OUT, BLACK, FADE_IN. All transitions occur only in a startOfFrame cycle.
  - NORMAL:
    - level_end pending -> FADE_OUT, fade_level = 15. level_end wins over hit.
    - else hit pending -> FLASH, frame counter = 0.
  - FLASH:
    - effect = FLASH on frames where counter[0] = 0, else NONE.
    - Counter increments each frame start. After FLASH_FRAMES frames -> NORMAL.
    - level_end pending aborts to FADE_OUT.
    - hit_evt during FLASH is dropped.
  - FADE_OUT:
    - effect = FADE. fade_level decrements once every FADE_STEP_FRAMES frame starts.
    - The frame start at which it reaches 0 enters BLACK and pulses fade_done.
    - hit_evt and level_end are dropped.
  - BLACK:
    - effect = FADE, fade_level = 0.
    - start_level pending -> FADE_IN. hit_evt is dropped.
  - FADE_IN:
    - effect = FADE. fade_level increments every FADE_STEP_FRAMES frames.
    - On reaching 15 -> NORMAL, effect = NONE in the same cycle.
    - level_end pending at that frame start is honoured on the next frame start.
  - start_level outside BLACK is cleared and ignored.
- Step counter width: $clog2(FADE_STEP_FRAMES + 1). fade_level saturates at 0 and 15 and never wraps.

## Timing
- sel_valid and sel_layer: registered, 1-cycle latency from layer_dr.
- effect, fade_level and busy: registered, updated the cycle after the startOfFrame that causes the transition.
- fade_done: high exactly one cycle, the cycle after the qualifying startOfFrame.
- An event pulse coincident with startOfFrame is consumed at that same frame start.
- Reset values: sel_valid 0, sel_layer 0, effect 0, fade_level 15, fade_done 0, busy 0. State NORMAL, all pending flags cleared, tables at identity.
- Reset mid-fade or mid-flash returns to these values the next cycle.

## Configuration
- LAYER_SCHED_FLASH_EN defined: FLASH state and hit pending flag are present, as above.
- LAYER_SCHED_FLASH_EN undefined: FLASH state, counter and flag are removed. hit_evt is ignored and effect never equals 1.

## Structure
- Package layer_sched_pkg holds:
  - effect_t enum (NONE/FLASH/FADE)
  - state_t enum
  - layer index constants (LAYER_PLAYER..LAYER_SPARE)
  - reset priority table constant
- Sub-module layer_prio_select: combinational priority scan (active table + layer_dr -> valid, index), instantiated once.

## Test plan
- After reset, layer_dr = 8'b0000_1001 -> next cycle sel_valid = 1, sel_layer = 0. With layer_dr = 0 -> sel_valid = 0.
- Write slot0 = 3 and slot3 = 0, then layer_dr = 8'b0000_1001:
  - before the next startOfFrame, sel_layer = 0
  - after it, sel_layer = 3
  - a write coincident with startOfFrame takes effect one frame later.
- hit_evt, then 8 frame starts (FLASH_FRAMES = 8): effect sequence 1,0,1,0,1,0,1,0 then 0 with busy = 0. Repeat with the macro undefined: effect stays 0.
- level_end:
  - fade_level steps 15 -> 0, one step per 4 frames.
  - fade_done pulses once at entry to BLACK, 60 frame starts after entry.
  - hit_evt in BLACK -> no change.
- start_level in BLACK: fade_level rises 0 -> 15 over 60 frames, then effect = 0 and busy = 0. start_level in NORMAL -> no change.
- Simultaneous hit_evt and level_end in NORMAL -> FADE_OUT. Assert reset mid-fade (fade_level = 7) -> fade_level = 15, effect = 0 next cycle.
